// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of a single 16x16 unsigned multiplier
// among NUM_REQ requesters. Operands are captured only on a grant, so the
// multiplier inputs stay still while idle. The registered result is returned
// to the granted requester through a valid/ready handshake.

module mult_asic_16x16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    assign p = {16'b0, a} * {16'b0, b};
endmodule

module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [31:0]           resp_p,
    output logic [IDX_W-1:0]      resp_idx,
    output logic                  busy,
    output logic [15:0]           ops_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [15:0]      r_op_a;
    logic [15:0]      r_op_b;
    logic [31:0]      r_res_q;
    logic [15:0]      r_ops_done;

    logic             w_found;
    logic [IDX_W-1:0] w_win;
    logic [IDX_W-1:0] w_win_next;
    logic [15:0]      w_sel_a;
    logic [15:0]      w_sel_b;
    logic [31:0]      w_prod;
    logic             w_resp_hs;

    // Round-robin search starting at r_rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        int unsigned v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            v_idx = 32'(r_rr_ptr) + i;
            if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
            if (!w_found && req_valid[v_idx[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = v_idx[IDX_W-1:0];
            end
        end
    end

    // Winner operands and the pointer value that follows the winner
    always_comb begin
        w_sel_a    = req_a[16*w_win +: 16];
        w_sel_b    = req_b[16*w_win +: 16];
        w_win_next = (w_win == IDX_W'(NUM_REQ-1)) ? '0 : w_win + 1'b1;
        w_resp_hs  = (r_state == S_RESP) && resp_ready[r_gnt_idx];
    end

    mult_asic_16x16 u_mult (
        .a (r_op_a),
        .b (r_op_b),
        .p (w_prod)
    );

    // Arbiter/multiplier FSM with operand isolation and saturating op counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_gnt_idx  <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_res_q    <= '0;
            r_ops_done <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_op_a    <= w_sel_a;
                        r_op_b    <= w_sel_b;
                        r_gnt_idx <= w_win;
                        r_rr_ptr  <= w_win_next;
                        r_state   <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_res_q <= w_prod;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (w_resp_hs) begin
                        r_state <= S_IDLE;
                        if (r_ops_done != 16'hFFFF) r_ops_done <= r_ops_done + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs; all forced to zero while reset is asserted
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        resp_p     = '0;
        resp_idx   = '0;
        busy       = 1'b0;
        ops_done   = '0;
        if (!rst) begin
            if (r_state == S_IDLE && w_found) req_ready[w_win] = 1'b1;
            if (r_state == S_RESP) resp_valid[r_gnt_idx] = 1'b1;
            resp_p   = r_res_q;
            resp_idx = r_gnt_idx;
            busy     = (r_state != S_IDLE);
            ops_done = r_ops_done;
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed testbench for mult_share_arbiter.
module tb_mult_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_ready;
    logic [31:0] resp_p;
    logic [1:0]  resp_idx;
    logic        busy;
    logic [15:0] ops_done;

    int checks   = 0;
    int failures = 0;

    mult_share_arbiter #(.NUM_REQ(4), .IDX_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_p     (resp_p),
        .resp_idx   (resp_idx),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and land 2 time units after it
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0]  one_hot;
        logic [31:0] exp_p;
        int          idx;

        rst        = 1'b1;
        req_valid  = 4'b1111;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 4'b1111;

        // Reset: outputs zero even with requests pending
        cyc();
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ops_done", 32'(ops_done), 32'h0);
        cyc();
        rst       = 1'b0;
        req_valid = 4'b0000;
        cyc();

        // Test 1: requester 1, 3*5
        req_valid     = 4'b0010;
        req_a[31:16]  = 16'h0003;
        req_b[31:16]  = 16'h0005;
        #1;
        chk("t1_req_ready", 32'(req_ready), 32'h2);
        chk("t1_busy_idle", 32'(busy), 32'h0);
        cyc();
        req_valid = 4'b0000;
        #1;
        chk("t1_mul_busy", 32'(busy), 32'h1);
        chk("t1_mul_resp_valid", 32'(resp_valid), 32'h0);
        cyc();
        #1;
        chk("t1_resp_valid", 32'(resp_valid), 32'h2);
        chk("t1_resp_idx", 32'(resp_idx), 32'h1);
        chk("t1_resp_p", resp_p, 32'h0000000F);
        cyc();
        #1;
        chk("t1_ops_done", 32'(ops_done), 32'h1);
        chk("t1_after_busy", 32'(busy), 32'h0);
        chk("t1_after_resp_valid", 32'(resp_valid), 32'h0);

        // Test 4: reset while in MUL drops the transaction
        req_valid    = 4'b0001;
        req_a[15:0]  = 16'h0007;
        req_b[15:0]  = 16'h0009;
        #1;
        chk("t4_req_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b0000;
        rst       = 1'b1;
        #1;
        chk("t4_in_reset_busy", 32'(busy), 32'h0);
        cyc();
        rst = 1'b0;
        #1;
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_resp_valid", 32'(resp_valid), 32'h0);
        chk("t4_rr_ptr", 32'(dut.r_rr_ptr), 32'h0);
        chk("t4_ops_done", 32'(ops_done), 32'h0);
        cyc();
        #1;
        chk("t4_no_late_resp", 32'(resp_valid), 32'h0);

        // Test 2: all valid, a_i=i+2, b_i=256*(i+1); order 0,1,2,3,0,1
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_a[16*i +: 16] = 16'(i + 2);
            req_b[16*i +: 16] = 16'(256 * (i + 1));
        end
        for (int g = 0; g < 6; g++) begin
            idx     = g % 4;
            one_hot = 4'b0001 << idx;
            exp_p   = 32'((idx + 2) * (idx + 1) * 256);
            #1;
            chk("t2_req_ready", 32'(req_ready), 32'(one_hot));
            cyc();
            #1;
            chk("t2_mul_req_ready", 32'(req_ready), 32'h0);
            cyc();
            #1;
            chk("t2_resp_valid", 32'(resp_valid), 32'(one_hot));
            chk("t2_resp_idx", 32'(resp_idx), 32'(idx));
            chk("t2_resp_p", resp_p, exp_p);
            cyc();
        end
        #1;
        chk("t2_ops_done", 32'(ops_done), 32'h6);

        // Test 3: requester 2 stalls its response for 10 cycles
        resp_ready = 4'b1011;
        chk("t3_req_ready", 32'(req_ready), 32'h4);
        cyc();
        cyc();
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("t3_hold_valid", 32'(resp_valid), 32'h4);
            chk("t3_hold_p", resp_p, 32'h00000C00);
            chk("t3_hold_req_ready", 32'(req_ready), 32'h0);
            cyc();
        end
        resp_ready = 4'b1111;
        #1;
        chk("t3_still_valid", 32'(resp_valid), 32'h4);
        cyc();
        #1;
        chk("t3_next_grant", 32'(req_ready), 32'h8);
        chk("t3_ops_done", 32'(ops_done), 32'h7);
        req_valid = 4'b0000;
        cyc();

        // Test 5: extreme operands and operand isolation while idle
        req_valid   = 4'b0001;
        req_a[15:0] = 16'hFFFF;
        req_b[15:0] = 16'hFFFF;
        #1;
        chk("t5a_req_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b0000;
        cyc();
        #1;
        chk("t5a_resp_idx", 32'(resp_idx), 32'h0);
        chk("t5a_resp_p", resp_p, 32'hFFFE0001);
        cyc();
        req_a = 64'hAAAA_5555_AAAA_5555;
        req_b = 64'h1111_2222_3333_4444;
        for (int c = 0; c < 3; c++) begin
            cyc();
            #1;
            chk("t5_hold_op_a", 32'(dut.r_op_a), 32'h0000FFFF);
            chk("t5_hold_op_b", 32'(dut.r_op_b), 32'h0000FFFF);
        end
        req_valid    = 4'b0100;
        req_a[47:32] = 16'h0000;
        req_b[47:32] = 16'h1234;
        #1;
        chk("t5b_req_ready", 32'(req_ready), 32'h4);
        cyc();
        req_valid = 4'b0000;
        cyc();
        #1;
        chk("t5b_resp_valid", 32'(resp_valid), 32'h4);
        chk("t5b_resp_p", resp_p, 32'h00000000);
        cyc();
        #1;
        chk("t5_ops_done", 32'(ops_done), 32'h9);

        // Test 6: counter saturation, preloaded near the limit
        force dut.r_ops_done = 16'hFFFE;
        #1;
        release dut.r_ops_done;
        cyc();
        #1;
        chk("t6_preload", 32'(ops_done), 32'h0000FFFE);
        req_a[31:16] = 16'h0002;
        req_b[31:16] = 16'h0002;
        for (int k = 0; k < 2; k++) begin
            req_valid = 4'b0010;
            cyc();
            req_valid = 4'b0000;
            cyc();
            #1;
            chk("t6_resp_p", resp_p, 32'h00000004);
            cyc();
            #1;
            chk("t6_ops_done", 32'(ops_done), 32'h0000FFFF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
